// File: rtl/pcie_mrd_splitter_pkg.sv
// Shared types and constants for the MRd request splitter: read-request size limits,
// the 4KB boundary, FSM state encoding and the request descriptor struct.
package pcie_mrd_splitter_pkg;

   localparam int MAX_READ_REQ_SIZE = 512;
   localparam int PCIE_4KB_BOUNDARY = 4096;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } split_state_e;

   // Descriptor body; the tag is carried separately because its width is a module parameter.
   typedef struct packed {
      logic [63:0] addr;
      logic [9:0]  len_dw;
      logic        fmt4dw;
      logic [3:0]  first_be;
      logic [3:0]  last_be;
   } mrd_req_t;

   // Bytes in the next request: min(remaining, MRRS, distance to the next 4KB boundary).
   // addr_lo must be DW aligned and rem_clamp already limited to 4096.
   function automatic logic [12:0] calc_chunk(input logic [11:0] addr_lo,
                                              input logic [12:0] rem_clamp);
      logic [12:0] to_boundary;
      logic [12:0] chunk;
      to_boundary = 13'(PCIE_4KB_BOUNDARY) - {1'b0, addr_lo};
      chunk       = 13'(MAX_READ_REQ_SIZE);
      if (to_boundary < chunk) chunk = to_boundary;
      if (rem_clamp < chunk)   chunk = rem_clamp;
      return chunk;
   endfunction

endpackage

// File: rtl/pcie_mrd_splitter_if.sv
// Command and request-descriptor bus of the MRd splitter. The slave modport is the
// splitter's view; the master modport is the DMA engine / header builder side.
interface pcie_mrd_splitter_if #(
   parameter int LEN_W = 20,
   parameter int TAG_W = 8
);
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic [63:0]      cmd_addr_i;
   logic [LEN_W-1:0] cmd_len_i;

   logic             mrd_valid_o;
   logic             mrd_ready_i;
   logic [63:0]      mrd_addr_o;
   logic [9:0]       mrd_len_dw_o;
   logic             mrd_4dw_o;
   logic [3:0]       mrd_first_be_o;
   logic [3:0]       mrd_last_be_o;
   logic [TAG_W-1:0] mrd_tag_o;
   logic             mrd_last_o;

   logic             tag_release_i;

   modport slave (
      input  cmd_valid_i, cmd_addr_i, cmd_len_i, mrd_ready_i, tag_release_i,
      output cmd_ready_o, mrd_valid_o, mrd_addr_o, mrd_len_dw_o, mrd_4dw_o,
             mrd_first_be_o, mrd_last_be_o, mrd_tag_o, mrd_last_o
   );

   modport master (
      output cmd_valid_i, cmd_addr_i, cmd_len_i, mrd_ready_i, tag_release_i,
      input  cmd_ready_o, mrd_valid_o, mrd_addr_o, mrd_len_dw_o, mrd_4dw_o,
             mrd_first_be_o, mrd_last_be_o, mrd_tag_o, mrd_last_o
   );

endinterface

// File: rtl/pcie_tag_alloc.sv
// Tag counter for MRd requests plus an optional outstanding-request limiter, enabled by
// defining PCIE_MRD_TAG_LIMIT_EN; without it the release input is ignored and full_o is 0.
module pcie_tag_alloc #(
   parameter int TAG_W    = 8,
   parameter int NUM_TAGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_fire_i,
   input  logic             release_i,
   output logic [TAG_W-1:0] tag_o,
   output logic             full_o
);

   logic [TAG_W-1:0] tag_q, tag_d;

   always_comb begin
      tag_d = tag_q;
      if (req_fire_i) tag_d = tag_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) tag_q <= '0;
      else     tag_q <= tag_d;
   end

   assign tag_o = tag_q;

`ifdef PCIE_MRD_TAG_LIMIT_EN
   localparam int CNT_W = $clog2(NUM_TAGS + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rel_ok;

   // A release against an empty count is dropped, so it cannot cancel a same-cycle request.
   always_comb begin
      rel_ok = release_i && (cnt_q != '0);
      cnt_d  = cnt_q;
      if (req_fire_i && !rel_ok)      cnt_d = cnt_q + 1'b1;
      else if (!req_fire_i && rel_ok) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign full_o = (cnt_q == CNT_W'(NUM_TAGS));
`else
   logic unused_release;
   assign unused_release = release_i;
   assign full_o         = 1'b0;
`endif

endmodule

// File: rtl/pcie_mrd_splitter.sv
// Splits DMA read commands into MRd descriptors of at most 512B that never cross a 4KB
// boundary. Optional outstanding-tag limit via PCIE_MRD_TAG_LIMIT_EN (see pcie_tag_alloc).
module pcie_mrd_splitter
   import pcie_mrd_splitter_pkg::*;
#(
   parameter int LEN_W    = 20,
   parameter int TAG_W    = 8,
   parameter int NUM_TAGS = 32
) (
   input logic                 clk,
   input logic                 rst,
   pcie_mrd_splitter_if.slave  bus
);

   split_state_e     state_q, state_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             valid_q, valid_d;
   mrd_req_t         req_q, req_d;
   logic             last_q, last_d;
   // Address and byte count of whatever follows the descriptor currently presented.
   logic [63:0]      addr_q, addr_d;
   logic [LEN_W-1:0] rem_q, rem_d;

   logic             cmd_fire;
   logic             mrd_fire;
   logic             mrd_valid;
   logic             tag_full;
   logic [TAG_W-1:0] tag_cur;

   logic [63:0]      src_addr;
   logic [LEN_W-1:0] src_rem;
   logic [12:0]      rem_clamp;
   logic [12:0]      chunk;
   logic [63:0]      nxt_addr;
   logic [LEN_W-1:0] nxt_rem;
   mrd_req_t         nxt_req;

   logic             unused_lsbs;
   assign unused_lsbs = ^{bus.cmd_addr_i[1:0], bus.cmd_len_i[1:0]};

   assign mrd_valid = valid_q & ~tag_full;
   assign cmd_fire  = bus.cmd_valid_i & cmd_ready_q;
   assign mrd_fire  = mrd_valid & bus.mrd_ready_i;

   pcie_tag_alloc #(
      .TAG_W    (TAG_W),
      .NUM_TAGS (NUM_TAGS)
   ) u_tag_alloc (
      .clk        (clk),
      .rst        (rst),
      .req_fire_i (mrd_fire),
      .release_i  (bus.tag_release_i),
      .tag_o      (tag_cur),
      .full_o     (tag_full)
   );

   // The first chunk comes straight from the command; later ones from the running state.
   always_comb begin
      if (state_q == ST_IDLE) begin
         src_addr = {bus.cmd_addr_i[63:2], 2'b00};
         src_rem  = {bus.cmd_len_i[LEN_W-1:2], 2'b00};
      end else begin
         src_addr = addr_q;
         src_rem  = rem_q;
      end

      if (src_rem >= LEN_W'(PCIE_4KB_BOUNDARY)) rem_clamp = 13'(PCIE_4KB_BOUNDARY);
      else                                      rem_clamp = src_rem[12:0];

      chunk    = calc_chunk(src_addr[11:0], rem_clamp);
      nxt_addr = src_addr + 64'(chunk);
      nxt_rem  = src_rem - LEN_W'(chunk);

      nxt_req.addr     = src_addr;
      nxt_req.len_dw   = 10'(chunk[12:2]);
      nxt_req.fmt4dw   = |src_addr[63:32];
      nxt_req.first_be = 4'hF;
      nxt_req.last_be  = (chunk == 13'd4) ? 4'h0 : 4'hF;
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      valid_d     = valid_q;
      req_d       = req_q;
      last_d      = last_q;
      addr_d      = addr_q;
      rem_d       = rem_q;

      case (state_q)
         ST_IDLE: begin
            // Zero-length commands are consumed here without leaving IDLE.
            if (cmd_fire && (src_rem != '0)) begin
               state_d     = ST_SPLIT;
               cmd_ready_d = 1'b0;
               valid_d     = 1'b1;
               req_d       = nxt_req;
               last_d      = (nxt_rem == '0);
               addr_d      = nxt_addr;
               rem_d       = nxt_rem;
            end
         end
         ST_SPLIT: begin
            if (mrd_fire) begin
               if (last_q) begin
                  state_d     = ST_IDLE;
                  cmd_ready_d = 1'b1;
                  valid_d     = 1'b0;
                  req_d       = '0;
                  last_d      = 1'b0;
                  addr_d      = '0;
                  rem_d       = '0;
               end else begin
                  req_d  = nxt_req;
                  last_d = (nxt_rem == '0);
                  addr_d = nxt_addr;
                  rem_d  = nxt_rem;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            valid_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         valid_q     <= 1'b0;
         req_q       <= '0;
         last_q      <= 1'b0;
         addr_q      <= '0;
         rem_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         valid_q     <= valid_d;
         req_q       <= req_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
      end
   end

   assign bus.cmd_ready_o    = cmd_ready_q;
   assign bus.mrd_valid_o    = mrd_valid;
   assign bus.mrd_addr_o     = req_q.addr;
   assign bus.mrd_len_dw_o   = req_q.len_dw;
   assign bus.mrd_4dw_o      = req_q.fmt4dw;
   assign bus.mrd_first_be_o = req_q.first_be;
   assign bus.mrd_last_be_o  = req_q.last_be;
   assign bus.mrd_tag_o      = tag_cur;
   assign bus.mrd_last_o     = last_q;

endmodule

// File: tb/tb_pcie_mrd_splitter.sv
// Scoreboard bench for pcie_mrd_splitter: a reference splitter pushes expected descriptors
// per command, and every descriptor handshake pops and compares one.
module tb_pcie_mrd_splitter;

   localparam int LEN_W    = 20;
   localparam int TAG_W    = 8;
   localparam int NUM_TAGS = 4;

   typedef struct {
      logic [63:0]      addr;
      logic [9:0]       len_dw;
      logic             fmt4dw;
      logic [3:0]       last_be;
      logic [TAG_W-1:0] tag;
      logic             last;
   } exp_t;

   logic clk;
   logic rst;

   pcie_mrd_splitter_if #(.LEN_W(LEN_W), .TAG_W(TAG_W)) bus ();

   pcie_mrd_splitter #(
      .LEN_W    (LEN_W),
      .TAG_W    (TAG_W),
      .NUM_TAGS (NUM_TAGS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t             exp_q[$];
   logic [TAG_W-1:0] exp_tag;
   int               total;
   int               bad;
   int               hs_count;
   exp_t             mon_e;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference splitter: min(remaining, 512, bytes to the next 4KB boundary).
   task automatic model_push(input logic [63:0] a, input logic [LEN_W-1:0] len);
      logic [63:0]     cur;
      longint unsigned rem;
      longint unsigned c;
      longint unsigned bnd;
      exp_t            e;
      cur = {a[63:2], 2'b00};
      rem = longint'({len[LEN_W-1:2], 2'b00});
      while (rem != 0) begin
         bnd = 4096 - longint'(cur & 64'hFFF);
         c   = 512;
         if (bnd < c) c = bnd;
         if (rem < c) c = rem;
         e.addr    = cur;
         e.len_dw  = 10'(c / 4);
         e.fmt4dw  = (cur[63:32] != 32'd0);
         e.last_be = (c == 4) ? 4'h0 : 4'hF;
         e.tag     = exp_tag;
         e.last    = (rem == c);
         exp_q.push_back(e);
         cur     = cur + 64'(c);
         rem     = rem - c;
         exp_tag = exp_tag + 1'b1;
      end
   endtask

   task automatic send_cmd(input logic [63:0] a, input logic [LEN_W-1:0] len);
      int n;
      n = 0;
      while (!bus.cmd_ready_o && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("cmd_ready", bus.cmd_ready_o, 1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_addr_i  = a;
      bus.cmd_len_i   = len;
      model_push(a, len);
      @(posedge clk); #1;
      bus.cmd_valid_i = 1'b0;
      check_val("first_valid", bus.mrd_valid_o, (len[LEN_W-1:2] != '0));
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && bus.cmd_ready_o) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check_val(tag, (exp_q.size() == 0 && bus.cmd_ready_o), 1);
   endtask

   task automatic check_front(input string tag);
      if (exp_q.size() == 0) begin
         check_val({tag, "_q_empty"}, 0, 1);
      end else begin
         check_val({tag, "_valid"}, bus.mrd_valid_o, 1);
         check_val({tag, "_addr"}, bus.mrd_addr_o, exp_q[0].addr);
         check_val({tag, "_len"}, bus.mrd_len_dw_o, exp_q[0].len_dw);
         check_val({tag, "_tag"}, bus.mrd_tag_o, exp_q[0].tag);
         check_val({tag, "_last"}, bus.mrd_last_o, exp_q[0].last);
      end
   endtask

   // Handshakes are sampled mid-cycle; they complete at the following rising edge.
   always @(negedge clk) begin
      if (!rst && bus.mrd_valid_o && bus.mrd_ready_i) begin
         hs_count++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_req", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check_val("req_addr", bus.mrd_addr_o, mon_e.addr);
            check_val("req_len_dw", bus.mrd_len_dw_o, mon_e.len_dw);
            check_val("req_4dw", bus.mrd_4dw_o, mon_e.fmt4dw);
            check_val("req_first_be", bus.mrd_first_be_o, 4'hF);
            check_val("req_last_be", bus.mrd_last_be_o, mon_e.last_be);
            check_val("req_tag", bus.mrd_tag_o, mon_e.tag);
            check_val("req_last", bus.mrd_last_o, mon_e.last);
            $display("req addr=%h len_dw=%0d 4dw=%0b tag=%0d last=%0b",
                     bus.mrd_addr_o, bus.mrd_len_dw_o, bus.mrd_4dw_o, bus.mrd_tag_o, bus.mrd_last_o);
         end
      end
   end

   initial begin
      int          hs_start;
      logic [63:0] ra;
      total    = 0;
      bad      = 0;
      hs_count = 0;
      exp_tag  = '0;
      rst      = 1'b1;
      bus.cmd_valid_i   = 1'b0;
      bus.cmd_addr_i    = '0;
      bus.cmd_len_i     = '0;
      bus.mrd_ready_i   = 1'b1;
      bus.tag_release_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_cmd_ready", bus.cmd_ready_o, 1);
      check_val("rst_valid", bus.mrd_valid_o, 0);
      check_val("rst_addr", bus.mrd_addr_o, 0);
      check_val("rst_len", bus.mrd_len_dw_o, 0);
      check_val("rst_first_be", bus.mrd_first_be_o, 0);
      check_val("rst_tag", bus.mrd_tag_o, 0);
      check_val("rst_last", bus.mrd_last_o, 0);
      rst = 1'b0;

      // MRRS split, 4KB split, 4DW single-DW request
      send_cmd(64'h1000, 20'd1024);
      wait_idle("drain_mrrs");
      send_cmd(64'h1F00, 20'd512);
      wait_idle("drain_4kb");
      send_cmd(64'h1_0000_0000, 20'd4);
      wait_idle("drain_4dw");

      // Carry into bit 32 flips the header format mid-command
      send_cmd(64'hFFFF_FFF0, 20'd64);
      wait_idle("drain_carry");

      // Zero-length command is swallowed
      send_cmd(64'h2000, 20'd3);
      @(posedge clk); #1;
      check_val("zero_len_valid", bus.mrd_valid_o, 0);
      check_val("zero_len_ready", bus.cmd_ready_o, 1);

      // Backpressure: descriptor must hold for 5 stalled cycles
      send_cmd(64'h3000, 20'd2048);
      @(posedge clk); #1;
      bus.mrd_ready_i = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         check_front("stall");
      end
      bus.mrd_ready_i = 1'b1;
      @(posedge clk); #1;
      check_front("resume");
      wait_idle("drain_stall");

      for (int i = 0; i < 6; i++) begin
         ra = {31'd0, 1'($urandom_range(0, 1)), 32'($urandom())};
         send_cmd(ra, LEN_W'($urandom_range(0, 3000)));
         wait_idle("drain_rand");
      end

`ifdef PCIE_MRD_TAG_LIMIT_EN
      // Outstanding limit: 4 requests then stall; one release admits exactly one more
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      exp_tag = '0;
      bus.tag_release_i = 1'b0;
      hs_start = hs_count;
      send_cmd(64'h0, 20'd4096);
      repeat (20) @(posedge clk);
      #1;
      check_val("limit_reqs", hs_count - hs_start, NUM_TAGS);
      check_val("limit_valid", bus.mrd_valid_o, 0);
      bus.tag_release_i = 1'b1;
      @(posedge clk); #1;
      bus.tag_release_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_val("limit_one_more", hs_count - hs_start, NUM_TAGS + 1);
      check_val("limit_valid2", bus.mrd_valid_o, 0);
      bus.tag_release_i = 1'b1;
      wait_idle("drain_limit");
`else
      hs_start = hs_count;
`endif

      // Reset during the 2nd of 8 requests
      send_cmd(64'h5000, 20'd4096);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("midrst_valid", bus.mrd_valid_o, 0);
      check_val("midrst_cmd_ready", bus.cmd_ready_o, 1);
      check_val("midrst_tag", bus.mrd_tag_o, 0);
      check_val("midrst_addr", bus.mrd_addr_o, 0);
      rst = 1'b0;
      exp_q.delete();
      exp_tag = '0;
      send_cmd(64'h6000, 20'd8);
      check_val("post_rst_tag", bus.mrd_tag_o, 0);
      wait_idle("drain_post_rst");

      check_val("hs_progress", (hs_count > hs_start), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
